// File: rtl/gca_rect_rd_pkg.sv
// Shared definitions for the rectangle reader: coordinate widths, FSM states, pixel tags.
package gca_rect_rd_pkg;

    localparam int unsigned X_W     = 11;
    localparam int unsigned Y_W     = 10;
    localparam int unsigned COORD_W = X_W + Y_W;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StDrain,
        StDone
    } gca_state_e;

    // Per-pixel position tags, computed when the read is issued.
    typedef struct packed {
        logic eol;
        logic last;
    } gca_tag_t;

endpackage

// File: rtl/gca_rect_rd_if.sv
// Framebuffer read bus plus outgoing pixel stream of the rectangle reader.
interface gca_rect_rd_if #(
    parameter int unsigned PIXW = 16
);
    logic [gca_rect_rd_pkg::COORD_W-1:0] ADDR;
    logic                                REQ;
    logic                                GNT;
    logic                                RVALID;
    logic [PIXW-1:0]                     RDATA;
    logic [PIXW-1:0]                     PIX;
    logic                                PIX_V;
    logic                                PIX_RDY;
    logic                                PIX_EOL;
    logic                                PIX_LAST;

    // Reader side.
    modport master (
        output ADDR, REQ, PIX, PIX_V, PIX_EOL, PIX_LAST,
        input  GNT, RVALID, RDATA, PIX_RDY
    );

    // Memory / pixel-sink side.
    modport slave (
        input  ADDR, REQ, PIX, PIX_V, PIX_EOL, PIX_LAST,
        output GNT, RVALID, RDATA, PIX_RDY
    );
endinterface

// File: rtl/gca_pix_fifo.sv
// Small synchronous FIFO with occupancy count; head is zero while empty.
module gca_pix_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is fine when the head leaves on the same edge.
    assign do_push = push && (!full || do_pop);
    assign rdata   = empty ? '0 : mem_q[rptr_q];

    // Storage array, written at the tail.
    always_ff @(posedge CLK) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= ptr_inc(wptr_q);
            end
            if (do_pop) begin
                rptr_q <= ptr_inc(rptr_q);
            end
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/gca_rect_rd.sv
// Rectangle reader: walks a framebuffer rectangle in raster order, issues reads and
// streams the returned pixels with end-of-row / end-of-rectangle tags.
module gca_rect_rd
    import gca_rect_rd_pkg::*;
#(
    parameter int unsigned PIXW  = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic [COORD_W-1:0] coord0,
    input  logic [COORD_W-1:0] coord1,
    input  logic               LD,
    gca_rect_rd_if.master      bus,
    output logic               BUSY,
    output logic               FC
);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned TW = $bits(gca_tag_t);

    gca_state_e       state_q, state_d;
    logic [X_W-1:0]   x0_q, x1_q, x_q;
    logic [Y_W-1:0]   y1_q, y_q;
    logic             x_end, y_end, at_end, rect_empty;
    logic             credit, gnt_fire, beat, pop;
    gca_tag_t         issue_tag, tag_head;
    logic             tag_full, tag_empty, pix_full, pix_empty;
    logic [CW-1:0]    tag_count, pix_count;
    logic [PIXW+TW-1:0] pix_head;
    logic             unused_full;

    // Equality flags only, so x1 = 2047 / y1 = 1023 terminate without wrapping.
    assign x_end      = (x_q == x1_q);
    assign y_end      = (y_q == y1_q);
    assign at_end     = x_end && y_end;
    assign rect_empty = (coord1[X_W-1:0] < coord0[X_W-1:0]) ||
                        (coord1[COORD_W-1:X_W] < coord0[COORD_W-1:X_W]);

    // Tag FIFO occupancy is the number of reads in flight.
    assign credit   = (32'(tag_count) + 32'(pix_count)) < DEPTH;
    assign bus.REQ  = (state_q == StIssue) && credit;
    assign bus.ADDR = {y_q, x_q};
    assign gnt_fire = bus.REQ && bus.GNT;
    // Beats with nothing in flight are leftovers from an abandoned transfer.
    assign beat     = bus.RVALID && !tag_empty;
    assign pop      = bus.PIX_V && bus.PIX_RDY;

    assign issue_tag = '{eol: x_end, last: at_end};

    assign bus.PIX      = pix_head[PIXW-1:0];
    assign bus.PIX_EOL  = pix_head[PIXW+1];
    assign bus.PIX_LAST = pix_head[PIXW];
    assign bus.PIX_V    = !pix_empty;

    assign BUSY = (state_q != StIdle);
    assign FC   = (state_q == StDone);

    assign unused_full = tag_full | pix_full;

    gca_pix_fifo #(
        .WIDTH (TW),
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .CLK   (CLK),
        .RST_N (RST_N),
        .push  (gnt_fire),
        .wdata (issue_tag),
        .pop   (beat),
        .rdata (tag_head),
        .full  (tag_full),
        .empty (tag_empty),
        .count (tag_count)
    );

    gca_pix_fifo #(
        .WIDTH (PIXW + TW),
        .DEPTH (DEPTH)
    ) u_pix_fifo (
        .CLK   (CLK),
        .RST_N (RST_N),
        .push  (beat),
        .wdata ({tag_head, bus.RDATA}),
        .pop   (pop),
        .rdata (pix_head),
        .full  (pix_full),
        .empty (pix_empty),
        .count (pix_count)
    );

    // FSM state register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: LD is only honoured in idle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (LD) state_d = rect_empty ? StDone : StIssue;
            StIssue: if (gnt_fire && at_end) state_d = StDrain;
            StDrain: if (pop && bus.PIX_LAST) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Rectangle bounds and raster-order read address.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            x0_q <= '0;
            x1_q <= '0;
            y1_q <= '0;
            x_q  <= '0;
            y_q  <= '0;
        end else if (state_q == StIdle && LD) begin
            x0_q <= coord0[X_W-1:0];
            x1_q <= coord1[X_W-1:0];
            y1_q <= coord1[COORD_W-1:X_W];
            x_q  <= coord0[X_W-1:0];
            y_q  <= coord0[COORD_W-1:X_W];
        end else if (gnt_fire && !at_end) begin
            if (x_end) begin
                x_q <= x0_q;
                y_q <= y_q + 1'b1;
            end else begin
                x_q <= x_q + 1'b1;
            end
        end
    end

endmodule
